// File: rtl/ship_motion_unit.sv
// Ship position register with tap and hold-to-repeat motion control.
// Moves saturate at the configured bounds and report moved or blocked pulses.
module ship_motion_unit #(
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int X_INIT        = 160,
  parameter int Y_INIT        = 195,
  parameter int X_MIN         = 5,
  parameter int X_MAX         = 305,
  parameter int Y_MIN         = 5,
  parameter int Y_MAX         = 225,
  parameter int STEP          = 5,
  parameter int HOLD_DELAY    = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           new_game,
  input  logic           game_playing,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           move_strobe,
  output logic           blocked,
  output logic [3:0]     dir_active
);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [X_W-1:0]   X_INIT_P    = X_W'(X_INIT);
  localparam logic [Y_W-1:0]   Y_INIT_P    = Y_W'(Y_INIT);
  localparam logic [X_W:0]     X_MIN_E     = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]     X_MAX_E     = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]     Y_MIN_E     = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0]     Y_MAX_E     = (Y_W+1)'(Y_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dir_q, dir_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d;
  logic             move_strobe_q, move_strobe_d;
  logic             blocked_q, blocked_d;
  logic             issue_move;
  logic             key_held;
  logic             at_bound;
  logic [X_W:0]     x_dec, x_inc;
  logic [Y_W:0]     y_dec, y_inc;

  assign key_held = |(dir_q & {up, down, left, right});

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dir_q         <= '0;
      pos_x_q       <= X_INIT_P;
      pos_y_q       <= Y_INIT_P;
      move_strobe_q <= 1'b0;
      blocked_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      move_strobe_q <= move_strobe_d;
      blocked_q     <= blocked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    issue_move = 1'b0;
    if (new_game) begin
      state_d = IDLE;
      cnt_d   = '0;
      dir_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (game_playing && (up || down || left || right)) begin
            state_d = HELD;
            cnt_d   = '0;
            if (up)        dir_d = 4'b1000;
            else if (down) dir_d = 4'b0100;
            else if (left) dir_d = 4'b0010;
            else           dir_d = 4'b0001;
          end
        end
        HELD: begin
          if (!game_playing) begin
            state_d = IDLE;
            dir_d   = '0;
          end else if (!key_held) begin
            issue_move = 1'b1;
            state_d    = IDLE;
            dir_d      = '0;
          end else if (cnt_q == HOLD_LAST) begin
            issue_move = 1'b1;
            cnt_d      = '0;
            state_d    = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          // Releasing during auto-repeat never produces a trailing step.
          if (!game_playing || !key_held) begin
            state_d = IDLE;
            dir_d   = '0;
          end else if (cnt_q == REPEAT_LAST) begin
            issue_move = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          dir_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    // One extra bit keeps a decrement below zero visible as the top bit.
    x_dec = {1'b0, pos_x_q} - (X_W+1)'(STEP);
    if (x_dec[X_W] || (x_dec < X_MIN_E)) x_dec = X_MIN_E;
    x_inc = {1'b0, pos_x_q} + (X_W+1)'(STEP);
    if (x_inc > X_MAX_E) x_inc = X_MAX_E;
    y_dec = {1'b0, pos_y_q} - (Y_W+1)'(STEP);
    if (y_dec[Y_W] || (y_dec < Y_MIN_E)) y_dec = Y_MIN_E;
    y_inc = {1'b0, pos_y_q} + (Y_W+1)'(STEP);
    if (y_inc > Y_MAX_E) y_inc = Y_MAX_E;

    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    move_strobe_d = 1'b0;
    blocked_d     = 1'b0;
    at_bound      = 1'b0;
    if (new_game) begin
      pos_x_d = X_INIT_P;
      pos_y_d = Y_INIT_P;
    end else if (issue_move) begin
      case (dir_q)
        4'b1000: begin
          at_bound = ({1'b0, pos_y_q} == Y_MIN_E);
          pos_y_d  = y_dec[Y_W-1:0];
        end
        4'b0100: begin
          at_bound = ({1'b0, pos_y_q} == Y_MAX_E);
          pos_y_d  = y_inc[Y_W-1:0];
        end
        4'b0010: begin
          at_bound = ({1'b0, pos_x_q} == X_MIN_E);
          pos_x_d  = x_dec[X_W-1:0];
        end
        default: begin
          at_bound = ({1'b0, pos_x_q} == X_MAX_E);
          pos_x_d  = x_inc[X_W-1:0];
        end
      endcase
      move_strobe_d = !at_bound;
      blocked_d     = at_bound;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign move_strobe = move_strobe_q;
  assign blocked     = blocked_q;
  assign dir_active  = dir_q;

endmodule

// File: doc/ship_motion_unit.md
Name: ship_motion_unit

Overview:
Parametrised successor to the ship movement FSM and datapath. It merges control and position registers into one block and adds hold-to-repeat motion: a tap gives one step on release, and a held key gives a step after HOLD_DELAY, then one step every REPEAT_PERIOD. Moves saturate at configurable bounds, and the block reports accepted and blocked moves. It sits between the keyboard decoder and the ship renderer/collision logic.

Parameters:
X_W, 10, width of pos_x
Y_W, 9, width of pos_y
X_INIT, 160, x position after reset/new_game
Y_INIT, 195, y position after reset/new_game
X_MIN, 5, lowest legal x (inclusive)
X_MAX, 305, highest legal x (inclusive)
Y_MIN, 5, lowest legal y (inclusive)
Y_MAX, 225, highest legal y (inclusive)
STEP, 5, pixels per move
HOLD_DELAY, 25000000, cycles a key must be held before the first auto-move (>=2)
REPEAT_PERIOD, 5000000, cycles between auto-moves (>=1)
CNT_W, 25, counter width; must hold max(HOLD_DELAY, REPEAT_PERIOD)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
new_game  in  1  synchronous restart: position to INIT, FSM to IDLE
game_playing  in  1  moves accepted only while high
up  in  1  key level
down  in  1  key level
left  in  1  key level
right  in  1  key level
pos_x  out  X_W  ship x (registered)
pos_y  out  Y_W  ship y (registered)
move_strobe  out  1  one-cycle pulse: position changed this cycle
blocked  out  1  one-cycle pulse: move requested but already at bound
dir_active  out  4  latched direction {up,down,left,right}, one-hot or 0

Behaviour:
- Reset (highest priority) and new_game give: state IDLE, pos_x=X_INIT, pos_y=Y_INIT, move_strobe=0, blocked=0, dir_active=0, counter=0. This applies mid-hold too, and no move issues that cycle.
- All outputs are registered. A move decided at edge N shows on pos_x/pos_y and the strobes from edge N onward; strobes clear at edge N+1.
- States: IDLE, HELD, REPEAT.
- IDLE, game_playing=1, any key high:
  - latch one direction by priority up>down>left>right into dir_active
  - counter=0, go to HELD
  - if no key is high, or game_playing=0, stay in IDLE
- HELD:
  - latched key low: issue one move (tap), go to IDLE, dir_active=0
  - else if counter==HOLD_DELAY-1: issue one move, counter=0, go to REPEAT
  - else counter+1
- REPEAT:
  - latched key low: go to IDLE with no move, dir_active=0
  - else if counter==REPEAT_PERIOD-1: issue one move, counter=0
  - else counter+1
- In HELD or REPEAT, game_playing=0 means go to IDLE with no move and dir_active=0. Key release and game_playing falling in the same cycle: no move.
- Non-latched keys are ignored while in HELD or REPEAT. Pressing a second key does not change direction.
- Move arithmetic uses X_W+1 / Y_W+1 bit intermediates, so there is no wrap-around:
  - up: pos_y = max(pos_y-STEP, Y_MIN)
  - down: pos_y = min(pos_y+STEP, Y_MAX)
  - left: pos_x = max(pos_x-STEP, X_MIN)
  - right: pos_x = min(pos_x+STEP, X_MAX)
- Strobe rules for an issued move:
  - position at the bound before the move: no change, blocked=1, move_strobe=0
  - otherwise (including a partial clamp): move_strobe=1, blocked=0
  - exactly one of the two pulses per issued move
- Only one axis changes per move. There are no diagonal moves.

Test Plan:
1. Reset high 2 cycles, then low -> pos_x=160, pos_y=195, dir_active=0, strobes 0. With game_playing=1, press right 3 cycles and release -> one move_strobe, pos_x=165, pos_y unchanged.
2. Sim params HOLD_DELAY=4, REPEAT_PERIOD=2; hold up for 10 cycles after HELD entry, then release -> exactly 4 move_strobes (cycles 4,6,8,10), pos_y 195->175, no extra move on release.
3. X_INIT=303, tap right -> pos_x=305, move_strobe=1. Tap right again -> pos_x=305, blocked=1, move_strobe=0. Repeat on left bound with X_INIT=7, tap left -> 5, then blocked.
4. Press up+left together -> dir_active=4'b1000, only pos_y changes. Release up while left still held -> one up move, IDLE, next cycle latches left.
5. game_playing=0 with keys held -> no state change. Drop game_playing mid-REPEAT -> IDLE, no move, dir_active=0.
6. Assert new_game, then reset, mid-hold with position (180,150) -> (160,195) next edge, IDLE, no strobe. Reset and new_game together -> same result.
